if_id_skid_reg: RTL and testbench
=================================

Name: if_id_skid_reg

Overview:
- IF→ID pipeline register of the 5-stage RV64 core, directly downstream of instruction fetch.
- Captures fetched PC/instruction and presents them to decode with valid/ready handshakes.
- Absorbs one extra instruction in a skid entry, so the IF stall (ready) is a registered signal with no combinational path from the ID stall.
- Supports branch flush (insert NOP bubble) and keeps a saturating ID-stall cycle counter.

Parameters:
XLEN, 64, PC width
ILEN, 32, instruction width
NOP_INST, 32'h0000_0013, instruction driven whenever output is invalid (addi x0,x0,0)
CNT_W, 32, stall counter width

Ports:
i_IFID_clk  input  1  clock
i_IFID_rst_n  input  1  asynchronous active-low reset
i_IFID_pc  input  XLEN  PC from IF
i_IFID_inst  input  ILEN  instruction from IF
i_IFID_valid  input  1  IF payload valid
o_IFID_ready  output  1  block can accept; low means IF holds its PC
i_IFID_flush  input  1  branch taken / redirect; kill all held instructions
o_IFID_pc  output  XLEN  PC to ID
o_IFID_inst  output  ILEN  instruction to ID (NOP_INST when invalid)
o_IFID_valid  output  1  ID payload valid
i_IFID_ready  input  1  ID can accept (low on load-use stall)
o_IFID_stall_cnt  output  CNT_W  cycles ID stalled while holding a valid instruction

Behaviour:
- One clock, i_IFID_clk. Reset is asynchronous and active-low on i_IFID_rst_n: on assertion, immediately, even mid-transfer, go to EMPTY with both entries invalid. Reset values:
  - o_IFID_pc = 0
  - o_IFID_inst = NOP_INST
  - o_IFID_valid = 0
  - o_IFID_ready = 1
  - o_IFID_stall_cnt = 0
- Handshake terms: in_fire = i_IFID_valid & o_IFID_ready; out_fire = o_IFID_valid & i_IFID_ready.
- Two storage entries:
  - main: drives the outputs.
  - skid: holds one overflow instruction.
- States: EMPTY (none valid), BUSY (main valid), FULL (main+skid valid).
- o_IFID_valid = (state != EMPTY); o_IFID_ready = (state != FULL). Both decode from state registers only.
- Transitions when flush is low:
  - EMPTY: in_fire → BUSY, main ← input.
  - BUSY:
    - in_fire & out_fire → BUSY, main ← input.
    - in_fire & !out_fire → FULL, skid ← input.
    - !in_fire & out_fire → EMPTY.
    - Otherwise hold.
  - FULL (in_fire impossible): out_fire → BUSY, main ← skid. Otherwise hold.
- Latency: input accepted in cycle N appears on outputs in cycle N+1 when the block is EMPTY or draining.
- Order is strict FIFO. No instruction is duplicated or dropped except by flush.
- Flush (priority over all handshakes):
  - Next state EMPTY.
  - Any same-cycle in_fire payload is discarded.
  - main.inst ← NOP_INST; main.pc retains its value.
  - Next cycle o_IFID_valid = 0 and o_IFID_ready = 1.
- While o_IFID_valid = 0, o_IFID_inst = NOP_INST regardless of stored data.
- Payload registers load only on the listed events; no other-cycle toggling.
- Stall counter:
  - Increments when o_IFID_valid & !i_IFID_ready & !i_IFID_flush.
  - Saturates at all-ones (no wrap).
  - Cleared only by reset.
- Widths: PC/instruction pass through unmodified; no arithmetic on PC.

Decomposition:
- Shared pipeline package holds:
  - XLEN/ILEN constants.
  - NOP_INST.
  - A packed struct if_id_payload_t {pc, inst}.
  - A state enum {EMPTY, BUSY, FULL}.
- One natural sub-module: sat_counter (parameter CNT_W; ports clk, rst_n, inc, count). Reused for later pipeline performance counters.

Test Plan:
- Reset mid-stream: assert rst_n low while FULL → outputs immediately valid=0, ready=1, inst=0x00000013, stall_cnt=0.
- Streaming: i_valid=1, i_ready=1 every cycle, PCs 0x8000_0000,+4,+8 → o_pc follows one cycle later each cycle, ready stays 1, stall_cnt stays 0.
- Skid fill:
  - Stimulus: BUSY holding 0x8000_0000, drop i_ready while IF presents 0x8000_0004.
  - Next cycle: state FULL, ready=0, output still 0x8000_0000.
  - Raise i_ready: outputs 0x8000_0000 then 0x8000_0004 on consecutive fires; ready returns to 1.
- Flush in FULL with same-cycle i_valid (pc 0x8000_0008) → next cycle valid=0, inst=NOP, ready=1; the 0x8000_0004 and 0x8000_0008 instructions never appear at the output.
- Stall counting: hold valid with i_ready=0 for 5 cycles → stall_cnt=5. Preload the counter path near CNT_W=4 (parameter override) and stall 20 cycles → stall_cnt saturates at 15.
- Flush priority over reset release: flush asserted in the first cycle after rst_n rises → state remains EMPTY, no spurious valid.

Source files
------------

// File: rtl/if_id_skid_reg_pkg.sv
// rtl/if_id_skid_reg_pkg.sv - shared IF/ID pipeline constants and types
package if_id_skid_reg_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
    } if_id_payload_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } if_id_state_e;

endpackage

// File: rtl/if_id_skid_reg_sat_counter.sv
// rtl/if_id_skid_reg_sat_counter.sv - saturating event counter, cleared only by reset
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/if_id_skid_reg.sv
// rtl/if_id_skid_reg.sv - IF/ID pipeline register with one skid entry and registered ready
module if_id_skid_reg
    import if_id_skid_reg_pkg::if_id_state_e;
    import if_id_skid_reg_pkg::EMPTY;
    import if_id_skid_reg_pkg::BUSY;
    import if_id_skid_reg_pkg::FULL;
#(
    parameter int              XLEN     = if_id_skid_reg_pkg::XLEN,
    parameter int              ILEN     = if_id_skid_reg_pkg::ILEN,
    parameter logic [ILEN-1:0] NOP_INST = ILEN'(if_id_skid_reg_pkg::NOP_INST),
    parameter int              CNT_W    = 32
) (
    input  logic             i_IFID_clk,
    input  logic             i_IFID_rst_n,
    input  logic [XLEN-1:0]  i_IFID_pc,
    input  logic [ILEN-1:0]  i_IFID_inst,
    input  logic             i_IFID_valid,
    output logic             o_IFID_ready,
    input  logic             i_IFID_flush,
    output logic [XLEN-1:0]  o_IFID_pc,
    output logic [ILEN-1:0]  o_IFID_inst,
    output logic             o_IFID_valid,
    input  logic             i_IFID_ready,
    output logic [CNT_W-1:0] o_IFID_stall_cnt
);

    if_id_state_e    state_q;
    logic [XLEN-1:0] main_pc_q;
    logic [ILEN-1:0] main_inst_q;
    logic [XLEN-1:0] skid_pc_q;
    logic [ILEN-1:0] skid_inst_q;

    logic in_fire;
    logic out_fire;
    logic stall_inc;

    // Handshake outputs decode from state only, keeping ID's stall off IF's ready path.
    assign o_IFID_valid = (state_q != EMPTY);
    assign o_IFID_ready = (state_q != FULL);
    assign o_IFID_pc    = main_pc_q;
    assign o_IFID_inst  = o_IFID_valid ? main_inst_q : NOP_INST;

    assign in_fire   = i_IFID_valid & o_IFID_ready;
    assign out_fire  = o_IFID_valid & i_IFID_ready;
    assign stall_inc = o_IFID_valid & ~i_IFID_ready & ~i_IFID_flush;

    always_ff @(posedge i_IFID_clk or negedge i_IFID_rst_n) begin
        if (!i_IFID_rst_n) begin
            state_q     <= EMPTY;
            main_pc_q   <= '0;
            main_inst_q <= NOP_INST;
            skid_pc_q   <= '0;
            skid_inst_q <= NOP_INST;
        end else if (i_IFID_flush) begin
            // Redirect kills both entries; PC is kept so the output bus stays quiet.
            state_q     <= EMPTY;
            main_inst_q <= NOP_INST;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_q     <= BUSY;
                        main_pc_q   <= i_IFID_pc;
                        main_inst_q <= i_IFID_inst;
                    end
                end
                BUSY: begin
                    if (in_fire && out_fire) begin
                        main_pc_q   <= i_IFID_pc;
                        main_inst_q <= i_IFID_inst;
                    end else if (in_fire) begin
                        state_q     <= FULL;
                        skid_pc_q   <= i_IFID_pc;
                        skid_inst_q <= i_IFID_inst;
                    end else if (out_fire) begin
                        state_q <= EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state_q     <= BUSY;
                        main_pc_q   <= skid_pc_q;
                        main_inst_q <= skid_inst_q;
                    end
                end
                default: begin
                    state_q <= EMPTY;
                end
            endcase
        end
    end

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_stall_cnt (
        .clk  (i_IFID_clk),
        .rst_n(i_IFID_rst_n),
        .inc  (stall_inc),
        .count(o_IFID_stall_cnt)
    );

endmodule

// File: tb/tb_if_id_skid_reg.sv
// tb/tb_if_id_skid_reg.sv - directed vector bench for if_id_skid_reg
module tb_if_id_skid_reg;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [63:0] PC0 = 64'h0000_0000_8000_0000;

    logic        clk;
    logic        rst_n;
    logic [63:0] in_pc;
    logic [31:0] in_inst;
    logic        in_valid;
    logic        flush;
    logic        id_ready;

    logic        if_ready;
    logic [63:0] out_pc;
    logic [31:0] out_inst;
    logic        out_valid;
    logic [31:0] stall_cnt;

    logic        if_ready4;
    logic [63:0] out_pc4;
    logic [31:0] out_inst4;
    logic        out_valid4;
    logic [3:0]  stall_cnt4;

    int tests;
    int fails;

    if_id_skid_reg u_dut (
        .i_IFID_clk      (clk),
        .i_IFID_rst_n    (rst_n),
        .i_IFID_pc       (in_pc),
        .i_IFID_inst     (in_inst),
        .i_IFID_valid    (in_valid),
        .o_IFID_ready    (if_ready),
        .i_IFID_flush    (flush),
        .o_IFID_pc       (out_pc),
        .o_IFID_inst     (out_inst),
        .o_IFID_valid    (out_valid),
        .i_IFID_ready    (id_ready),
        .o_IFID_stall_cnt(stall_cnt)
    );

    if_id_skid_reg #(.CNT_W(4)) u_dut4 (
        .i_IFID_clk      (clk),
        .i_IFID_rst_n    (rst_n),
        .i_IFID_pc       (in_pc),
        .i_IFID_inst     (in_inst),
        .i_IFID_valid    (in_valid),
        .o_IFID_ready    (if_ready4),
        .i_IFID_flush    (flush),
        .o_IFID_pc       (out_pc4),
        .o_IFID_inst     (out_inst4),
        .o_IFID_valid    (out_valid4),
        .i_IFID_ready    (id_ready),
        .o_IFID_stall_cnt(stall_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk_inst(input logic [63:0] pc);
        return pc[31:0] + 32'h1000_0003;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fl, input logic v, input logic [63:0] pc, input logic ir);
        flush    = fl;
        in_valid = v;
        in_pc    = pc;
        in_inst  = mk_inst(pc);
        id_ready = ir;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic r,
                           input logic [63:0] pc, input logic [31:0] cnt);
        chk({tag, ".valid"}, 64'(out_valid), 64'(v));
        chk({tag, ".ready"}, 64'(if_ready), 64'(r));
        chk({tag, ".pc"}, out_pc, pc);
        chk({tag, ".inst"}, 64'(out_inst), 64'(v ? mk_inst(pc) : NOP));
        chk({tag, ".cnt"}, 64'(stall_cnt), 64'(cnt));
    endtask

    typedef struct {
        logic        fl;
        logic        v;
        logic [63:0] pc;
        logic        ir;
        logic        exp_v;
        logic        exp_r;
        logic [63:0] exp_pc;
        logic [31:0] exp_cnt;
    } vec_t;

    vec_t vecs[10];

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 64'h0, 1'b1);

        vecs[0] = '{1'b0, 1'b1, PC0,         1'b1, 1'b1, 1'b1, PC0,         0};
        vecs[1] = '{1'b0, 1'b1, PC0 + 64'h4, 1'b1, 1'b1, 1'b1, PC0 + 64'h4, 0};
        vecs[2] = '{1'b0, 1'b1, PC0 + 64'h8, 1'b1, 1'b1, 1'b1, PC0 + 64'h8, 0};
        vecs[3] = '{1'b0, 1'b0, 64'h0,       1'b1, 1'b0, 1'b1, PC0 + 64'h8, 0};
        vecs[4] = '{1'b0, 1'b1, 64'h10,      1'b0, 1'b1, 1'b1, 64'h10,      0};
        vecs[5] = '{1'b0, 1'b1, 64'h14,      1'b0, 1'b1, 1'b0, 64'h10,      1};
        vecs[6] = '{1'b0, 1'b1, 64'h18,      1'b0, 1'b1, 1'b0, 64'h10,      2};
        vecs[7] = '{1'b0, 1'b1, 64'h18,      1'b1, 1'b1, 1'b1, 64'h14,      2};
        vecs[8] = '{1'b0, 1'b1, 64'h18,      1'b1, 1'b1, 1'b1, 64'h18,      2};
        vecs[9] = '{1'b0, 1'b0, 64'h0,       1'b1, 1'b0, 1'b1, 64'h18,      2};

        step();
        step();
        chk_out("reset", 1'b0, 1'b1, 64'h0, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].fl, vecs[i].v, vecs[i].pc, vecs[i].ir);
            step();
            chk_out($sformatf("vec%0d", i), vecs[i].exp_v, vecs[i].exp_r,
                    vecs[i].exp_pc, vecs[i].exp_cnt);
        end

        // Skid fill then drain in order
        drive(1'b0, 1'b1, PC0, 1'b1);         step(); chk_out("skid_a", 1'b1, 1'b1, PC0, 2);
        drive(1'b0, 1'b1, PC0 + 64'h4, 1'b0); step(); chk_out("skid_full", 1'b1, 1'b0, PC0, 3);
        drive(1'b0, 1'b0, 64'h0, 1'b1);       step(); chk_out("skid_drain", 1'b1, 1'b1, PC0 + 64'h4, 3);
        drive(1'b0, 1'b0, 64'h0, 1'b1);       step(); chk_out("skid_empty", 1'b0, 1'b1, PC0 + 64'h4, 3);

        // Flush while FULL with a same-cycle offer
        drive(1'b0, 1'b1, PC0, 1'b1);         step(); chk_out("fl_busy", 1'b1, 1'b1, PC0, 3);
        drive(1'b0, 1'b1, PC0 + 64'h4, 1'b0); step(); chk_out("fl_full", 1'b1, 1'b0, PC0, 4);
        drive(1'b1, 1'b1, PC0 + 64'h8, 1'b0); step(); chk_out("fl_flush", 1'b0, 1'b1, PC0, 4);
        drive(1'b0, 1'b0, 64'h0, 1'b1);       step(); chk_out("fl_after1", 1'b0, 1'b1, PC0, 4);
        drive(1'b0, 1'b0, 64'h0, 1'b0);       step(); chk_out("fl_after2", 1'b0, 1'b1, PC0, 4);

        // Asynchronous reset while FULL
        drive(1'b0, 1'b1, 64'h30, 1'b0);      step(); chk_out("rst_busy", 1'b1, 1'b1, 64'h30, 4);
        drive(1'b0, 1'b1, 64'h34, 1'b0);      step(); chk_out("rst_full", 1'b1, 1'b0, 64'h30, 5);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("rst_async", 1'b0, 1'b1, 64'h0, 0);
        chk("rst_async.cnt4", 64'(stall_cnt4), 64'h0);
        step();
        rst_n = 1'b1;

        // Stall counting and saturation of the narrow counter
        drive(1'b0, 1'b1, 64'h40, 1'b0);      step(); chk_out("st_load", 1'b1, 1'b1, 64'h40, 0);
        drive(1'b0, 1'b0, 64'h0, 1'b0);
        for (int i = 0; i < 5; i++) step();
        chk_out("st_5", 1'b1, 1'b1, 64'h40, 5);
        chk("st_5.cnt4", 64'(stall_cnt4), 64'd5);
        for (int i = 0; i < 15; i++) step();
        chk_out("st_20", 1'b1, 1'b1, 64'h40, 20);
        chk("st_20.cnt4", 64'(stall_cnt4), 64'd15);
        chk("st_20.valid4", 64'(out_valid4), 64'd1);
        drive(1'b1, 1'b0, 64'h0, 1'b0);       step(); chk_out("st_flush", 1'b0, 1'b1, 64'h40, 20);
        chk("st_flush.cnt4", 64'(stall_cnt4), 64'd15);

        // Flush in the first cycle after reset release
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        drive(1'b1, 1'b1, 64'h50, 1'b1);      step(); chk_out("rel_flush", 1'b0, 1'b1, 64'h0, 0);
        drive(1'b0, 1'b0, 64'h0, 1'b1);       step(); chk_out("rel_after", 1'b0, 1'b1, 64'h0, 0);
        chk("rel_after.valid4", 64'(out_valid4), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
